// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared widths and vector/mask types for the MLP backward datapath
// Optional feature macro used by consumers: RELU_LEAKY_GRAD_EN
package mlp_pkg;

   localparam int INPUT_WIDTH = 3;
   localparam int DATA_WIDTH  = 16;
   localparam int MASK_DEPTH  = 8;
   localparam int LEAK_SHIFT  = 3;
   localparam int PTR_W       = $clog2(MASK_DEPTH);
   localparam int CNT_W       = $clog2(MASK_DEPTH + 1);

   typedef logic signed [DATA_WIDTH-1:0] data_t;
   typedef data_t vec_t [INPUT_WIDTH];
   typedef logic [INPUT_WIDTH-1:0] relu_mask_t;

   // Strictly positive test on a signed element; zero maps to a cleared mask bit.
   function automatic logic is_positive(input data_t a);
      return !a[DATA_WIDTH-1] && (a != '0);
   endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// rtl/relu_mask_fifo.sv - synchronous FIFO of forward ReLU masks with occupancy count
// Caller guarantees pop only when not empty, push only when not full or popping.
module relu_mask_fifo
   import mlp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  relu_mask_t       wdata,
   output relu_mask_t       rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   relu_mask_t       mem_q [MASK_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // When full, a simultaneous push lands in the slot being read this cycle;
   // the read is combinational so the old entry is consumed before the write.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_W'(MASK_DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/relu_backward.sv
// rtl/relu_backward.sv - ReLU backward gate: stores forward sign masks, gates upstream gradients
// Define RELU_LEAKY_GRAD_EN to pass masked-off gradients scaled by 2^-LEAK_SHIFT instead of zero.
module relu_backward
   import mlp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             fwd_valid,
   output logic             fwd_ready,
   input  vec_t             fwd_a_in,
   input  logic             grad_valid,
   output logic             grad_ready,
   input  vec_t             grad_in,
   output logic             gout_valid,
   input  logic             gout_ready,
   output vec_t             grad_out,
   output logic [CNT_W-1:0] mask_count
);

   logic       push, pop, full, empty;
   relu_mask_t new_mask, head_mask;
   vec_t       gated;
   vec_t       grad_out_q, grad_out_d;
   logic       gout_valid_q, gout_valid_d;

   relu_mask_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (new_mask),
      .rdata (head_mask),
      .full  (full),
      .empty (empty),
      .count (mask_count)
   );

   assign grad_ready = !empty && (!gout_valid_q || gout_ready);
   assign pop        = grad_valid && grad_ready;
   // A full FIFO still accepts a mask in the same cycle one is consumed.
   assign fwd_ready  = !rst && (!full || pop);
   assign push       = fwd_valid && fwd_ready;

   always_comb begin
      new_mask = '0;
      for (int i = 0; i < INPUT_WIDTH; i++) begin
         new_mask[i] = is_positive(fwd_a_in[i]);
      end
   end

   always_comb begin
      for (int i = 0; i < INPUT_WIDTH; i++) begin
`ifdef RELU_LEAKY_GRAD_EN
         gated[i] = head_mask[i] ? grad_in[i] : (grad_in[i] >>> LEAK_SHIFT);
`else
         gated[i] = head_mask[i] ? grad_in[i] : '0;
`endif
      end
   end

   always_comb begin
      grad_out_d   = grad_out_q;
      gout_valid_d = gout_valid_q;
      if (pop) begin
         grad_out_d   = gated;
         gout_valid_d = 1'b1;
      end else if (gout_ready) begin
         gout_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gout_valid_q <= 1'b0;
         for (int i = 0; i < INPUT_WIDTH; i++) grad_out_q[i] <= '0;
      end else begin
         gout_valid_q <= gout_valid_d;
         grad_out_q   <= grad_out_d;
      end
   end

   assign gout_valid = gout_valid_q;
   assign grad_out   = grad_out_q;

endmodule

// File: tb/tb_relu_backward.sv
// tb/tb_relu_backward.sv - directed self-checking bench for relu_backward
// Leaky expectations follow RELU_LEAKY_GRAD_EN when the bench is built with it.
module tb_relu_backward;
   import mlp_pkg::*;

   logic             clk, rst;
   logic             fwd_valid, fwd_ready;
   vec_t             fwd_a_in;
   logic             grad_valid, grad_ready;
   vec_t             grad_in;
   logic             gout_valid, gout_ready;
   vec_t             grad_out;
   logic [CNT_W-1:0] mask_count;

   int n_checks = 0;
   int n_fail   = 0;

   relu_backward dut (
      .clk        (clk),
      .rst        (rst),
      .fwd_valid  (fwd_valid),
      .fwd_ready  (fwd_ready),
      .fwd_a_in   (fwd_a_in),
      .grad_valid (grad_valid),
      .grad_ready (grad_ready),
      .grad_in    (grad_in),
      .gout_valid (gout_valid),
      .gout_ready (gout_ready),
      .grad_out   (grad_out),
      .mask_count (mask_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input int e0, input int e1, input int e2);
      check({tag, ".valid"}, gout_valid, 1);
      check({tag, ".g0"}, grad_out[0], e0);
      check({tag, ".g1"}, grad_out[1], e1);
      check({tag, ".g2"}, grad_out[2], e2);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit [2:0] msk_of(input int k);
      return 3'((k * 5 + 3) % 8);
   endfunction

   task automatic set_fwd(input int k);
      bit [2:0] m;
      m = msk_of(k);
      for (int i = 0; i < INPUT_WIDTH; i++)
         fwd_a_in[i] = m[i] ? data_t'(k + 1) : ((k % 3 == 0) ? data_t'(0) : data_t'(-(k + 1)));
   endtask

   task automatic set_grad(input int j);
      for (int i = 0; i < INPUT_WIDTH; i++) grad_in[i] = data_t'(j * 4 + i + 1);
   endtask

   task automatic push_vec(input int a0, input int a1, input int a2);
      fwd_a_in   = '{data_t'(a0), data_t'(a1), data_t'(a2)};
      fwd_valid  = 1'b1;
      step();
      fwd_valid  = 1'b0;
   endtask

   bit [2:0] mq[$];
   bit [2:0] em;
   int       p;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      fwd_valid  = 1'b0;
      grad_valid = 1'b0;
      gout_ready = 1'b1;
      fwd_a_in   = '{default: '0};
      grad_in    = '{default: '0};
      repeat (3) step();
      check("rst.fwd_ready", fwd_ready, 0);
      check("rst.count", mask_count, 0);
      check("rst.gout_valid", gout_valid, 0);
      check("rst.grad_ready", grad_ready, 0);
      check("rst.g0", grad_out[0], 0);
      rst = 1'b0;
      step();

      // Empty FIFO stalls the gradient
      grad_in = '{data_t'(1), data_t'(2), data_t'(3)};
      grad_valid = 1'b1;
      #1;
      check("empty.grad_ready", grad_ready, 0);
      check("empty.fwd_ready", fwd_ready, 1);
      step();
      check("empty.gout_valid", gout_valid, 0);
      grad_valid = 1'b0;

      // Basic
      push_vec(5, -3, 0);
      check("basic.count", mask_count, 1);
      grad_in = '{data_t'(100), data_t'(200), data_t'(-50)};
      grad_valid = 1'b1;
      #1;
      check("basic.grad_ready", grad_ready, 1);
      step();
      grad_valid = 1'b0;
      check_out("basic", 100, 0, 0);
      check("basic.count_after", mask_count, 0);
      step();
      check("basic.valid_drop", gout_valid, 0);

      // Order
      push_vec(1, 2, 3);
      push_vec(-1, -2, -3);
      push_vec(4, -5, 6);
      check("order.count", mask_count, 3);
      grad_in = '{data_t'(7), data_t'(7), data_t'(7)};
      grad_valid = 1'b1;
      step();
      check_out("order0", 7, 7, 7);
      step();
      check_out("order1", 0, 0, 0);
      step();
      check_out("order2", 7, 0, 7);
      grad_valid = 1'b0;
      step();
      check("order.count_end", mask_count, 0);

      // Full, simultaneous push/pop and wrap over 20 vectors
      for (int k = 0; k < 8; k++) begin
         set_fwd(k);
         fwd_valid = 1'b1;
         step();
         mq.push_back(msk_of(k));
      end
      fwd_valid = 1'b0;
      #1;
      check("full.count", mask_count, 8);
      check("full.fwd_ready", fwd_ready, 0);
      p = 0;
      for (int k = 8; k < 20; k++) begin
         set_fwd(k);
         fwd_valid  = 1'b1;
         set_grad(p);
         grad_valid = 1'b1;
         #1;
         check("pp.fwd_ready", fwd_ready, 1);
         check("pp.grad_ready", grad_ready, 1);
         step();
         em = mq.pop_front();
         mq.push_back(msk_of(k));
         check_out("pp", em[0] ? p*4+1 : 0, em[1] ? p*4+2 : 0, em[2] ? p*4+3 : 0);
         check("pp.count", mask_count, 8);
         p++;
      end
      fwd_valid = 1'b0;
      for (int n = 0; n < 8; n++) begin
         set_grad(p);
         grad_valid = 1'b1;
         step();
         em = mq.pop_front();
         check_out("drain", em[0] ? p*4+1 : 0, em[1] ? p*4+2 : 0, em[2] ? p*4+3 : 0);
         p++;
      end
      grad_valid = 1'b0;
      step();
      check("drain.count", mask_count, 0);
      check("drain.gout_valid", gout_valid, 0);

      // Backpressure
      push_vec(1, 1, 1);
      push_vec(1, 1, 1);
      push_vec(1, 1, 1);
      gout_ready = 1'b0;
      grad_in = '{data_t'(11), data_t'(12), data_t'(13)};
      grad_valid = 1'b1;
      step();
      check_out("bp.first", 11, 12, 13);
      grad_in = '{data_t'(21), data_t'(22), data_t'(23)};
      for (int n = 0; n < 4; n++) begin
         check("bp.grad_ready", grad_ready, 0);
         step();
         check_out("bp.hold", 11, 12, 13);
         check("bp.count", mask_count, 2);
      end
      gout_ready = 1'b1;
      #1;
      check("bp.release_ready", grad_ready, 1);
      step();
      check_out("bp.second", 21, 22, 23);
      grad_in = '{data_t'(31), data_t'(32), data_t'(33)};
      step();
      check_out("bp.third", 31, 32, 33);
      grad_valid = 1'b0;
      step();
      check("bp.valid_drop", gout_valid, 0);
      check("bp.count_end", mask_count, 0);

      // Leaky / non-leaky masked-off elements
      push_vec(-1, 1, -1);
      grad_in = '{data_t'(64), data_t'(64), data_t'(-9)};
      grad_valid = 1'b1;
      step();
      grad_valid = 1'b0;
`ifdef RELU_LEAKY_GRAD_EN
      check_out("leaky", 8, 64, -2);
`else
      check_out("leaky", 0, 64, 0);
`endif
      step();

      // Reset mid-stream
      push_vec(3, 3, 3);
      push_vec(4, 4, 4);
      grad_in = '{data_t'(9), data_t'(9), data_t'(9)};
      grad_valid = 1'b1;
      step();
      grad_valid = 1'b0;
      check_out("mid.pre", 9, 9, 9);
      check("mid.pre_count", mask_count, 1);
      rst = 1'b1;
      #1;
      check("mid.gout_valid", gout_valid, 0);
      check("mid.count", mask_count, 0);
      check("mid.grad_ready", grad_ready, 0);
      check("mid.g0", grad_out[0], 0);
      check("mid.g2", grad_out[2], 0);
      check("mid.fwd_ready", fwd_ready, 0);
      step();
      rst = 1'b0;
      step();
      check("mid.post_count", mask_count, 0);
      check("mid.post_fwd_ready", fwd_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
